gate_op_arbiter: RTL and testbench

- Shares one registered logic-gate unit (AND/OR/XOR/NAND) between N_REQ requesters.
- Grants one requester per cycle using round-robin priority.
- Computes the selected operation on that requester's operands and holds the result in a single-entry output register with valid/ready backpressure.
- Sits between multiple testbench/driver-side requesters and the gate datapath. It is the scheduler for the shared gate resource.

---
 rtl/gate_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 35 +++
 rtl/gate_op_arbiter.sv | 71 +++++++
 tb/tb_gate_op_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// Shared definitions for the gate datapath: opcode encoding and the gate evaluation function.
package gate_pkg;

    // Widest operand gate_eval handles; callers zero-extend and truncate to their own width.
    localparam int GATE_MAX_W = 32;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } gate_op_e;

    function automatic logic [GATE_MAX_W-1:0] gate_eval(
        input gate_op_e               op,
        input logic [GATE_MAX_W-1:0]  a,
        input logic [GATE_MAX_W-1:0]  b
    );
        logic [GATE_MAX_W-1:0] y;
        unique case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
        endcase
        return y;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: grants the first asserted request scanning from ptr upward, modulo N.
module rr_arbiter #(
    parameter  int N   = 4,
    localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req,
    input  logic           en,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_idx
);

    // One extra bit so ptr+k never overflows before the modulo fold (N need not be a power of 2).
    logic [IDW:0] j;
    logic         found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = '0;
        for (int k = 0; k < N; k++) begin
            j = {1'b0, ptr} + (IDW+1)'(k);
            if (j >= (IDW+1)'(N)) begin
                j = j - (IDW+1)'(N);
            end
            if (en && !found && req[j[IDW-1:0]]) begin
                found               = 1'b1;
                gnt[j[IDW-1:0]]     = 1'b1;
                gnt_idx             = j[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/gate_op_arbiter.sv
// Schedules N_REQ requesters onto one registered gate unit; result held in a single-entry
// valid/ready output register.
module gate_op_arbiter
    import gate_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = 1,
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ*2-1:0]     req_op,
    output logic [N_REQ-1:0]       gnt,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_y,
    output logic [IDW-1:0]     rsp_id
);

    // Handshakes: a request is taken in the cycle gnt[i]=1 (requester holds req and operands
    // until then); a result transfers in any cycle where rsp_valid && rsp_ready, and a new
    // result may be loaded in that same cycle so throughput is one result per clock.

    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   gnt_idx;
    logic             can_accept;
    logic             arb_en;
    logic             any_gnt;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    gate_op_e         op_sel;
    logic [WIDTH-1:0] y_next;

    assign can_accept = !rsp_valid || rsp_ready;
    // Grants are suppressed while reset is held so requesters see no acceptance.
    assign arb_en     = can_accept && rst_n;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req     (req),
        .en      (arb_en),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign any_gnt = |gnt;
    assign a_sel   = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
    assign b_sel   = req_b[int'(gnt_idx)*WIDTH +: WIDTH];
    assign op_sel  = gate_op_e'(req_op[int'(gnt_idx)*2 +: 2]);
    assign y_next  = WIDTH'(gate_eval(op_sel, GATE_MAX_W'(a_sel), GATE_MAX_W'(b_sel)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            rsp_valid <= 1'b0;
            rsp_y     <= '0;
            rsp_id    <= '0;
        end else if (any_gnt) begin
            rsp_valid <= 1'b1;
            rsp_y     <= y_next;
            rsp_id    <= gnt_idx;
            ptr       <= (gnt_idx == IDW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Bench for gate_op_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_gate_op_arbiter;

    localparam int N_REQ = 4;
    localparam int WIDTH = 1;
    localparam int IDW   = 2;
    localparam int EW    = IDW + WIDTH;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [N_REQ-1:0]       req = '0;
    logic [N_REQ*WIDTH-1:0] req_a = '0;
    logic [N_REQ*WIDTH-1:0] req_b = '0;
    logic [N_REQ*2-1:0]     req_op = '0;
    logic                   rsp_ready = 1'b0;
    logic [N_REQ-1:0]       gnt;
    logic                   rsp_valid;
    logic [WIDTH-1:0]       rsp_y;
    logic [IDW-1:0]         rsp_id;

    gate_op_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_id    (rsp_id)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard state
    int               n_checks = 0;
    int               n_fail   = 0;
    logic [EW-1:0]    exp_q[$];
    logic [EW-1:0]    m_last = '0;
    int               m_ptr  = 0;
    logic [N_REQ-1:0] obs_gnt;
    logic [IDW-1:0]   obs_id;
    logic [WIDTH-1:0] obs_y;
    logic             obs_valid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] model_op(input logic [1:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    // Expected grant: slot free when empty or being drained; first request at or after m_ptr.
    function automatic logic [N_REQ-1:0] model_gnt();
        logic [N_REQ-1:0] g;
        g = '0;
        if (exp_q.size() != 0 && !rsp_ready) return g;
        for (int k = 0; k < N_REQ; k++) begin
            int i;
            i = (m_ptr + k) % N_REQ;
            if (req[i]) begin
                g[i] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_last = '0;
        m_ptr  = 0;
    endtask

    // One clock: sample and compare at negedge, advance model, return just after posedge.
    task automatic step();
        logic [N_REQ-1:0] eg;
        int               gi;
        @(negedge clk);
        obs_gnt   = gnt;
        obs_id    = rsp_id;
        obs_y     = rsp_y;
        obs_valid = rsp_valid;
        eg = model_gnt();
        check("gnt", 32'(gnt), 32'(eg));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_q.size() != 0));
        check("rsp_id", 32'(rsp_id), 32'(m_last[EW-1:WIDTH]));
        check("rsp_y", 32'(rsp_y), 32'(m_last[WIDTH-1:0]));
        if (exp_q.size() != 0 && rsp_ready) void'(exp_q.pop_front());
        if (eg != 0) begin
            gi = $clog2(eg);
            m_last = {IDW'(gi), model_op(req_op[gi*2 +: 2], req_a[gi*WIDTH +: WIDTH],
                                         req_b[gi*WIDTH +: WIDTH])};
            exp_q.push_back(m_last);
            m_ptr = (gi + 1) % N_REQ;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_all(input logic [N_REQ-1:0] r, input logic [1:0] op,
                             input logic a, input logic b);
        req = r;
        for (int i = 0; i < N_REQ; i++) begin
            req_op[i*2 +: 2]       = op;
            req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
            req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
        end
    endtask

    logic [WIDTH-1:0] op_exp [4];

    initial begin
        op_exp[0] = 1'b0; op_exp[1] = 1'b1; op_exp[2] = 1'b1; op_exp[3] = 1'b1;

        // reset with all requesting: nothing granted, outputs cleared
        drive_all(4'b1111, 2'b00, 1'b1, 1'b1);
        rsp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_gnt", 32'(gnt), 0);
            check("rst_valid", 32'(rsp_valid), 0);
            check("rst_y", 32'(rsp_y), 0);
            check("rst_id", 32'(rsp_id), 0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();

        // round robin over all four, AND of 1,1
        for (int k = 0; k < 9; k++) begin
            step();
            if (k == 0) check("first_gnt", 32'(obs_gnt), 32'h1);
            if (k >= 1) begin
                check("rr_id", 32'(obs_id), 32'((k - 1) % 4));
                check("rr_y", 32'(obs_y), 1);
            end
        end

        // opcodes on requester 2 with a=1, b=0
        req = 4'b0100;
        req_a[2*WIDTH +: WIDTH] = 1'b1;
        req_b[2*WIDTH +: WIDTH] = 1'b0;
        for (int o = 0; o < 5; o++) begin
            if (o < 4) req_op[4 +: 2] = 2'(o);
            else       req = '0;
            step();
            if (o > 0) begin
                check("op_id", 32'(obs_id), 2);
                check("op_y", 32'(obs_y), 32'(op_exp[o-1]));
            end
        end

        // backpressure: ptr=3, req 0110 -> grant 1, then stall five cycles
        req = 4'b0110;
        rsp_ready = 1'b0;
        step();
        check("bp_first_gnt", 32'(obs_gnt), 32'h2);
        for (int c = 0; c < 5; c++) begin
            step();
            check("bp_gnt", 32'(obs_gnt), 0);
            check("bp_id", 32'(obs_id), 1);
            check("bp_valid", 32'(obs_valid), 1);
        end
        rsp_ready = 1'b1;
        step();
        check("bp_pop_gnt", 32'(obs_gnt), 32'h4);
        req = 4'b0101;
        step();
        check("bp_valid_kept", 32'(obs_valid), 1);
        // ptr now 3 with req 0101: wrap to 0, then skip to 2
        check("skip_gnt0", 32'(obs_gnt), 32'h1);
        step();
        check("skip_gnt2", 32'(obs_gnt), 32'h4);

        // random traffic with requesters holding until granted
        for (int c = 0; c < 400; c++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
            for (int i = 0; i < N_REQ; i++) begin
                if (obs_gnt[i] || !req[i]) begin
                    req[i]                  = 1'($urandom_range(0, 1));
                    req_a[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 1));
                    req_b[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 1));
                    req_op[i*2 +: 2]        = 2'($urandom_range(0, 3));
                end
            end
        end

        // asynchronous reset while a result is pending
        req = 4'b1111;
        rsp_ready = 1'b0;
        step();
        step();
        check("pre_rst_valid", 32'(obs_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(rsp_valid), 0);
        check("async_rst_gnt", 32'(gnt), 0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        req = 4'b1010;
        rsp_ready = 1'b1;
        step();
        check("post_rst_gnt", 32'(obs_gnt), 32'h2);
        step();
        check("post_rst_id", 32'(obs_id), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
